regfile_mp: RTL and testbench

Parametrised multi-port register file that succeeds the fixed 32x32, two-read/one-write register file in the datapath. Generalised width, depth and read-port count, with:
- a second write port, with per-byte enables on both write ports;
- optional hardwired-zero register 0;
- optional same-cycle write-to-read bypass;
- a sequenced bulk-clear operation with a busy/done handshake.

It sits between decode (read addresses) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_mp_if.sv | 38 +++
 rtl/regfile_clr_seq.sv | 59 +++++
 rtl/regfile_mp.sv | 92 +++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types, default widths and the byte-merge helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned MAX_DATA_W = 512;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_CLEAR,
    CLR_DONE
  } clr_state_t;

  // Overlay the enabled bytes of wdata onto cur; callers widen to MAX_DATA_W and truncate back.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] cur,
    input logic [MAX_DATA_W-1:0] wdata,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = cur;
    for (int k = 0; k < int'(MAX_BE_W); k++) begin
      if (be[k]) res[k*8 +: 8] = wdata[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write ports, read ports and clear handshake of the multi-port register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = 2
);

  logic                       wr_en_a;
  logic [ADDR_W-1:0]          wr_addr_a;
  logic [DATA_W-1:0]          wr_data_a;
  logic [DATA_W/8-1:0]        wr_be_a;
  logic                       wr_en_b;
  logic [ADDR_W-1:0]          wr_addr_b;
  logic [DATA_W-1:0]          wr_data_b;
  logic [DATA_W/8-1:0]        wr_be_b;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       clr_req;
  logic                       clr_busy;
  logic                       clr_done;

  modport master (
    output wr_en_a, wr_addr_a, wr_data_a, wr_be_a,
    output wr_en_b, wr_addr_b, wr_data_b, wr_be_b,
    output rd_addr, clr_req,
    input  rd_data, clr_busy, clr_done
  );

  modport slave (
    input  wr_en_a, wr_addr_a, wr_data_a, wr_be_a,
    input  wr_en_b, wr_addr_b, wr_data_b, wr_be_b,
    input  rd_addr, clr_req,
    output rd_data, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks ptr over every register once, then pulses done.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_wr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  // Status flags are registered alongside the state so they stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLR_IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      clr_busy <= (state_nxt == CLR_CLEAR);
      clr_done <= (state_nxt == CLR_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLR_IDLE: begin
        if (clr_req) begin
          state_nxt = CLR_CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLR_CLEAR: begin
        if (ptr == LAST_ADDR) state_nxt = CLR_DONE;
        else                  ptr_nxt   = ptr + ADDR_W'(1);
      end
      CLR_DONE:  state_nxt = CLR_IDLE;
      default:   state_nxt = CLR_IDLE;
    endcase
  end

  assign clr_wr_en = clr_busy;
  assign clr_addr  = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two byte-enabled write ports, NUM_RD read ports, bypass and bulk clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DATA_W-1:0]        nxt [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_flat;
  logic                     acc_a, acc_b;
  logic                     clr_busy, clr_done, clr_wr_en;
  logic [ADDR_W-1:0]        clr_addr;

  // An address is live if it is in range and not the hardwired zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (bus.clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .clr_wr_en (clr_wr_en),
    .clr_addr  (clr_addr)
  );

  assign acc_a = bus.wr_en_a && addr_live(bus.wr_addr_a) && !clr_busy;
  assign acc_b = bus.wr_en_b && addr_live(bus.wr_addr_b) && !clr_busy;

  // Post-write value of every entry; B is applied after A so it wins on shared bytes.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      nxt[i] = mem[i];
      if (acc_a && (bus.wr_addr_a == ADDR_W'(i))) begin
        nxt[i] = DATA_W'(byte_merge(MAX_DATA_W'(nxt[i]), MAX_DATA_W'(bus.wr_data_a),
                                    MAX_BE_W'(bus.wr_be_a)));
      end
      if (acc_b && (bus.wr_addr_b == ADDR_W'(i))) begin
        nxt[i] = DATA_W'(byte_merge(MAX_DATA_W'(nxt[i]), MAX_DATA_W'(bus.wr_data_b),
                                    MAX_BE_W'(bus.wr_be_b)));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (clr_wr_en && (clr_addr == ADDR_W'(i))) mem[i] <= '0;
        else                                        mem[i] <= nxt[i];
      end
    end
  end

  // Bypass reads the post-write value; nxt already excludes dropped writes.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    rd_flat = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      ra  = bus.rd_addr[p*ADDR_W +: ADDR_W];
      val = '0;
      if (addr_live(ra)) begin
        val = (BYPASS != 0) ? nxt[IDX_W'(ra)] : mem[IDX_W'(ra)];
      end
      rd_flat[p*DATA_W +: DATA_W] = val;
    end
  end

  assign bus.rd_data  = rd_flat;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing 32-entry build and a non-bypassing 24-entry build.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b1 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b0 ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0))
    u0 (.clk(clk), .rst(rst), .bus(b0));

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int nb;
  bit sd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b1.wr_en_a = 0; b1.wr_addr_a = '0; b1.wr_data_a = '0; b1.wr_be_a = '0;
    b1.wr_en_b = 0; b1.wr_addr_b = '0; b1.wr_data_b = '0; b1.wr_be_b = '0;
    b1.clr_req = 0;
    b0.wr_en_a = 0; b0.wr_addr_a = '0; b0.wr_data_a = '0; b0.wr_be_a = '0;
    b0.wr_en_b = 0; b0.wr_addr_b = '0; b0.wr_data_b = '0; b0.wr_be_b = '0;
    b0.clr_req = 0;
  endtask

  task automatic set_a1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    b1.wr_en_a = 1; b1.wr_addr_a = a; b1.wr_data_a = d; b1.wr_be_a = be;
  endtask

  task automatic set_b1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    b1.wr_en_b = 1; b1.wr_addr_b = a; b1.wr_data_b = d; b1.wr_be_b = be;
  endtask

  task automatic set_a0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    b0.wr_en_a = 1; b0.wr_addr_a = a; b0.wr_data_a = d; b0.wr_be_a = be;
  endtask

  task automatic set_b0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    b0.wr_en_b = 1; b0.wr_addr_b = a; b0.wr_data_b = d; b0.wr_be_b = be;
  endtask

  function automatic logic [31:0] rd1(input int p);
    return b1.rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rd0(input int p);
    return b0.rd_data[p*32 +: 32];
  endfunction

  // Request a clear on u1 and follow it; optionally probe a dropped write or reset partway.
  task automatic run_clear(input int drop_at, input int rst_at, output int nbusy, output bit saw_done);
    bit stepped;
    b1.clr_req = 1;
    step();
    b1.clr_req = 0;
    nbusy = 0;
    saw_done = 0;
    for (int c = 0; c < 200; c++) begin
      stepped = 0;
      if (b1.clr_done) saw_done = 1;
      if (!b1.clr_busy) break;
      nbusy++;
      if (nbusy == rst_at) begin
        rst = 1;
        #1;
        return;
      end
      if (nbusy == drop_at) begin
        set_a1(5'd1, 32'hFFFF_FFFF, 4'hF);
        b1.rd_addr[9:5] = 5'd1;
        b1.rd_addr[4:0] = 5'd20;
        #1;
        check("clr_no_bypass", rd1(1), 32'h0);
        check("clr_old_entry", rd1(0), 32'h1414_1414);
        step();
        b1.wr_en_a = 0;
        #1;
        check("clr_write_dropped", rd1(1), 32'h0);
        stepped = 1;
      end
      if (!stepped) step();
    end
  endtask

  initial begin
    idle();
    b1.rd_addr = '0;
    b0.rd_addr = '0;
    rst = 1;
    step();
    step();
    check("rst_busy", b1.clr_busy, 1'b0);
    check("rst_done", b1.clr_done, 1'b0);
    rst = 0;
    #1;
    for (int i = 0; i < 32; i++) begin
      b1.rd_addr[4:0] = 5'(i);
      #1;
      check("reset_read", rd1(0), 32'h0);
    end
    check("idle_busy", b1.clr_busy, 1'b0);
    check("idle_done", b1.clr_done, 1'b0);
    step();

    // Byte-enable merge on r5
    set_a1(5'd5, 32'hDEAD_BEEF, 4'hF);
    step();
    set_a1(5'd5, 32'h0000_1122, 4'h3);
    b1.rd_addr[4:0] = 5'd5;
    #1;
    check("be_bypass", rd1(0), 32'hDEAD_1122);
    step();
    b1.wr_en_a = 0;
    #1;
    check("be_merge", rd1(0), 32'hDEAD_1122);

    // Hardwired zero register
    set_a1(5'd0, 32'hFFFF_FFFF, 4'hF);
    b1.rd_addr[9:5] = 5'd0;
    #1;
    check("zero_bypass", rd1(1), 32'h0);
    step();
    b1.wr_en_a = 0;
    #1;
    check("zero_reg", rd1(1), 32'h0);

    // Same-address conflict: B wins on bytes 0 and 2
    set_a1(5'd7, 32'h1111_1111, 4'hF);
    set_b1(5'd7, 32'h2222_2222, 4'h5);
    b1.rd_addr[9:5] = 5'd7;
    #1;
    check("conflict_bypass", rd1(1), 32'h1122_1122);
    step();
    idle();
    b1.rd_addr[4:0] = 5'd7;
    #1;
    check("conflict_array", rd1(0), 32'h1122_1122);

    // Bypass build: new value visible in the write cycle
    set_a1(5'd9, 32'hCAFE_F00D, 4'hF);
    b1.rd_addr[9:5] = 5'd9;
    #1;
    check("bypass_full", rd1(1), 32'hCAFE_F00D);
    step();
    idle();
    set_b1(5'd9, 32'h0000_00AA, 4'h1);
    #1;
    check("bypass_partial", rd1(1), 32'hCAFE_F0AA);
    step();
    idle();
    #1;
    check("bypass_array", rd1(1), 32'hCAFE_F0AA);

    // Non-bypass build: old value in the write cycle, new value after
    set_a0(5'd9, 32'h1234_5678, 4'hF);
    step();
    set_a0(5'd9, 32'hCAFE_F00D, 4'hF);
    b0.rd_addr[9:5] = 5'd9;
    #1;
    check("nobyp_old", rd0(1), 32'h1234_5678);
    step();
    idle();
    #1;
    check("nobyp_new", rd0(1), 32'hCAFE_F00D);
    set_a0(5'd0, 32'hA5A5_A5A5, 4'hF);
    step();
    idle();
    b0.rd_addr[4:0] = 5'd0;
    #1;
    check("r0_writable", rd0(0), 32'hA5A5_A5A5);
    set_a0(5'd23, 32'h2323_2323, 4'hF);
    set_b0(5'd24, 32'hFFFF_FFFF, 4'hF);
    step();
    idle();
    b0.rd_addr[4:0] = 5'd23;
    b0.rd_addr[9:5] = 5'd24;
    #1;
    check("last_entry", rd0(0), 32'h2323_2323);
    check("out_of_range", rd0(1), 32'h0);

    // Bulk clear with a dropped write and a write in DONE
    for (int i = 1; i < 32; i++) begin
      set_a1(5'(i), 32'(i) * 32'h0101_0101, 4'hF);
      step();
    end
    idle();
    run_clear(3, 0, nb, sd);
    check("clr_busy_len", 32'(nb), 32'd32);
    check("clr_done_seen", 32'(sd), 32'd1);
    check("done_busy_low", b1.clr_busy, 1'b0);
    set_a1(5'd3, 32'h0000_0033, 4'hF);
    step();
    idle();
    check("done_one_cycle", b1.clr_done, 1'b0);
    check("back_idle_busy", b1.clr_busy, 1'b0);
    for (int i = 0; i < 32; i++) begin
      b1.rd_addr[4:0] = 5'(i);
      #1;
      check("post_clear_read", rd1(0), (i == 3) ? 32'h0000_0033 : 32'h0);
    end
    step();

    // Reset in the middle of a clear
    set_a1(5'd5, 32'h5555_5555, 4'hF);
    step();
    set_a1(5'd31, 32'h3131_3131, 4'hF);
    step();
    idle();
    run_clear(0, 10, nb, sd);
    check("midrst_busy", b1.clr_busy, 1'b0);
    check("midrst_done", b1.clr_done, 1'b0);
    check("midrst_no_done", 32'(sd), 32'd0);
    b1.rd_addr[4:0] = 5'd5;
    b1.rd_addr[9:5] = 5'd31;
    #1;
    check("midrst_r5", rd1(0), 32'h0);
    check("midrst_r31", rd1(1), 32'h0);
    step();
    check("midrst_hold_done", b1.clr_done, 1'b0);
    rst = 0;
    step();
    check("after_rst_done", b1.clr_done, 1'b0);
    check("after_rst_busy", b1.clr_busy, 1'b0);
    run_clear(0, 0, nb, sd);
    check("reclr_busy_len", 32'(nb), 32'd32);
    check("reclr_done_seen", 32'(sd), 32'd1);
    step();
    check("reclr_done_low", b1.clr_done, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
